// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_pkg
//  Description : Shared definitions for the subtractive GCD controller.
//                It holds the 3-bit FSM state encodings, the X/Y and
//                input-bus mux select values, and the default iteration
//                budget and counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package gcd_pkg;

    localparam logic [2:0] GCD_IDLE   = 3'd0;
    localparam logic [2:0] GCD_LOAD_B = 3'd1;
    localparam logic [2:0] GCD_CALC   = 3'd2;
    localparam logic [2:0] GCD_DONE   = 3'd3;
    localparam logic [2:0] GCD_ERR    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = GCD_IDLE,
        ST_LOAD_B = GCD_LOAD_B,
        ST_CALC   = GCD_CALC,
        ST_DONE   = GCD_DONE,
        ST_ERR    = GCD_ERR
    } gcd_state_t;

    // X/Y mux selects: 0 routes register A, 1 routes register B
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Register input bus: external operand or subtractor result
    localparam logic SEL_IN_EXT = 1'b1;
    localparam logic SEL_IN_SUB = 1'b0;

    localparam int GCD_MAX_ITER_DEFAULT = 65535;
    localparam int GCD_CNT_W_DEFAULT    = 16;

endpackage
`default_nettype wire

// File: rtl/gcd_iter_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_iter_counter
//  Description : Subtract-step counter for one GCD operation. It can be
//                cleared, increments by one, saturates at MAX_ITER and
//                flags when that budget has been reached.
//  Ports       : clk, rst_n (sync, active low), clear, inc,
//                count [CNT_W-1:0], at_limit
//  Revision    : 1.0  initial release
// ============================================================================
module gcd_iter_counter
    import gcd_pkg::*;
#(
    parameter int MAX_ITER = GCD_MAX_ITER_DEFAULT,
    parameter int CNT_W    = GCD_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(MAX_ITER);

    logic [CNT_W-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (r_count == C_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && !w_at_limit) begin
            // Hold at the budget; the value never wraps back to zero
            r_count <= r_count + 1'b1;
        end
    end

    assign count    = r_count;
    assign at_limit = w_at_limit;

endmodule
`default_nettype wire

// File: rtl/gcd_controller.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_controller
//  Description : FSM that sequences the 16-bit subtractive GCD datapath.
//                It takes operand A and then operand B from a valid/ready
//                stream and runs one subtraction per cycle until eq. It
//                then pulses done, or pulses err when the iteration budget
//                runs out.
//  Ports       : clk, rst_n (sync, active low), in_valid/in_ready,
//                lt/gt/eq flags in, ldA/ldB/sel1/sel2/sel_in controls out,
//                busy/done/err status,
//                iter_count [CNT_W-1:0] (only with GCD_ITER_COUNT_EN)
//  Config      : GCD_ITER_COUNT_EN - adds the iter_count port and its
//                capture register
//  Revision    : 1.0  initial release
// ============================================================================
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int MAX_ITER = GCD_MAX_ITER_DEFAULT,
    parameter int CNT_W    = GCD_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             lt,
    input  logic             gt,
    input  logic             eq,
    output logic             ldA,
    output logic             ldB,
    output logic             sel1,
    output logic             sel2,
    output logic             sel_in,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [CNT_W-1:0] iter_count
`endif
);

    gcd_state_t r_state;
    gcd_state_t w_next;
    logic       w_clr;
    logic       w_inc;
    logic       w_at_limit;

`ifdef GCD_ITER_COUNT_EN
    logic [CNT_W-1:0] w_cnt;
`else
    // Count value is only consumed by the optional capture register
    logic [CNT_W-1:0] w_cnt_unused;
`endif

    gcd_iter_counter #(
        .MAX_ITER (MAX_ITER),
        .CNT_W    (CNT_W)
    ) u_iter_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_clr),
        .inc      (w_inc),
`ifdef GCD_ITER_COUNT_EN
        .count    (w_cnt),
`else
        .count    (w_cnt_unused),
`endif
        .at_limit (w_at_limit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        ldA      = 1'b0;
        ldB      = 1'b0;
        sel1     = SEL_A;
        sel2     = SEL_A;
        sel_in   = SEL_IN_SUB;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        w_clr    = 1'b0;
        w_inc    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                sel_in   = SEL_IN_EXT;
                if (in_valid) begin
                    ldA    = 1'b1;
                    w_next = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                in_ready = 1'b1;
                sel_in   = SEL_IN_EXT;
                busy     = 1'b1;
                if (in_valid) begin
                    ldB    = 1'b1;
                    w_clr  = 1'b1;
                    w_next = ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                // eq wins over the budget so an answer found on the last
                // permitted step is still reported as done
                if (eq) begin
                    w_next = ST_DONE;
                end else if (w_at_limit) begin
                    w_next = ST_ERR;
                end else if (gt) begin
                    sel1  = SEL_A;
                    sel2  = SEL_B;
                    ldA   = 1'b1;
                    w_inc = 1'b1;
                end else if (lt) begin
                    sel1  = SEL_B;
                    sel2  = SEL_A;
                    ldB   = 1'b1;
                    w_inc = 1'b1;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                busy   = 1'b1;
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                err    = 1'b1;
                busy   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        // While reset is asserted the old state may still be showing, so
        // nothing may touch the datapath or accept an operand.
        if (!rst_n) begin
            in_ready = 1'b0;
            ldA      = 1'b0;
            ldB      = 1'b0;
            w_clr    = 1'b0;
            w_inc    = 1'b0;
        end
    end

`ifdef GCD_ITER_COUNT_EN
    logic [CNT_W-1:0] r_iter_count;

    // Snapshot the step count on the edge that enters DONE or ERR
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_iter_count <= '0;
        end else if (r_state == ST_CALC && (eq || w_at_limit)) begin
            r_iter_count <= w_cnt;
        end
    end

    assign iter_count = r_iter_count;
`endif

endmodule
`default_nettype wire
